// File: rtl/seq_multiplier.sv
// rtl/seq_multiplier.sv - iterative shift-add multiplier, signed/unsigned, one bit per clock
// Optional feature macro: MULTIPLIER_ACCUMULATE_EN (adds accumulate input, product += A*B)
module seq_multiplier #(
  parameter int N  = 4,
  parameter int CW = $clog2(N + 1)
) (
  input  logic           clock,
  input  logic           n_reset,
  input  logic           start,
  input  logic           is_signed,
  input  logic [N-1:0]   multiplicand,
  input  logic [N-1:0]   multiplier,
`ifdef MULTIPLIER_ACCUMULATE_EN
  input  logic           accumulate,
`endif
  output logic           ready,
  output logic           done,
  output logic [2*N-1:0] product
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t        state, next_state;
  logic [N-1:0]  a_r;
  logic          sgn_r;
  logic [N:0]    hi;
  logic [N-1:0]  lo;
  logic [CW-1:0] count;
`ifdef MULTIPLIER_ACCUMULATE_EN
  logic          acc_r;
`endif

  logic           last, sub, shift_in;
  logic [N:0]     addend, term, sum;
  logic [2*N-1:0] result;

  // hi carries one guard bit: the carry in unsigned mode, the sign in signed mode
  always_comb begin
    last     = (count == CW'(1));
    sub      = sgn_r & last;
    addend   = sgn_r ? {a_r[N-1], a_r} : {1'b0, a_r};
    term     = lo[0] ? (sub ? ~addend : addend) : '0;
    sum      = hi + term + {{N{1'b0}}, lo[0] & sub};
    shift_in = sgn_r ? sum[N] : 1'b0;
    result   = {sum, lo[N-1:1]};
  end

  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) state <= IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = BUSY;
      BUSY:    if (last)  next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  assign ready = (state == IDLE);
  assign done  = (state == DONE);

  // product is written on the edge entering DONE so it is valid while done is high
  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      a_r     <= '0;
      sgn_r   <= 1'b0;
      hi      <= '0;
      lo      <= '0;
      count   <= '0;
      product <= '0;
`ifdef MULTIPLIER_ACCUMULATE_EN
      acc_r   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (start) begin
          a_r   <= multiplicand;
          sgn_r <= is_signed;
          hi    <= '0;
          lo    <= multiplier;
          count <= CW'(N);
`ifdef MULTIPLIER_ACCUMULATE_EN
          acc_r <= accumulate;
`endif
        end
        BUSY: begin
          hi    <= {shift_in, sum[N:1]};
          lo    <= {sum[0], lo[N-1:1]};
          count <= count - CW'(1);
          if (last) begin
`ifdef MULTIPLIER_ACCUMULATE_EN
            product <= acc_r ? product + result : result;
`else
            product <= result;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule
